// File: rtl/reg_file_mp.sv
// Multi-port register file for the ID stage.
// - Two write ports. Port 1 is the younger one and wins when both write the same register.
// - A per-register busy scoreboard that the hazard unit reads.
// - An optional same-cycle write-to-read bypass.
// - Register 0 can be hardwired to zero.
module reg_file_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NRD      = 2,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [AW-1:0]         waddr0,
    input  logic [AW-1:0]         waddr1,
    input  logic [XLEN-1:0]       wd0,
    input  logic [XLEN-1:0]       wd1,
    input  logic                  res_en,
    input  logic [AW-1:0]         res_addr,
    output logic [NREGS-1:0]      busy_vec
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_nxt;
    logic             wr_ok0;
    logic             wr_ok1;
    logic             res_ok;
    logic [AW-1:0]    ra;
    logic [XLEN-1:0]  rdat;
    logic             rbsy;

    // A write or reserve is legal unless it targets the hardwired zero register.
    assign wr_ok0 = we0 && !(ZERO_REG && (waddr0 == '0));
    assign wr_ok1 = we1 && !(ZERO_REG && (waddr1 == '0));
    assign res_ok = res_en && !(ZERO_REG && (res_addr == '0));

    // Register storage. Port 1 is assigned last, so it wins a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (wr_ok0) begin
                regs_q[waddr0] <= wd0;
            end
            if (wr_ok1) begin
                regs_q[waddr1] <= wd1;
            end
        end
    end

    // Next scoreboard state: writebacks clear their busy bit.
    // A reserve is applied last because it comes from a newer producer.
    always_comb begin
        busy_nxt = busy_q;
        if (wr_ok0) begin
            busy_nxt[waddr0] = 1'b0;
        end
        if (wr_ok1) begin
            busy_nxt[waddr1] = 1'b0;
        end
        if (res_ok) begin
            busy_nxt[res_addr] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    assign busy_vec = busy_q;

    // Read ports, each resolved independently. Priority is: zero register, then we1, then we0, then stored state.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        rdat    = '0;
        rbsy    = 1'b0;
        for (int p = 0; p < int'(NRD); p++) begin
            ra   = rd_addr[p*AW +: AW];
            rdat = regs_q[ra];
            rbsy = busy_q[ra];
            if (BYPASS) begin
                if (we0 && (waddr0 == ra)) begin
                    rdat = wd0;
                    rbsy = 1'b0;
                end
                if (we1 && (waddr1 == ra)) begin
                    rdat = wd1;
                    rbsy = 1'b0;
                end
            end
            // Reset masks the bypass as well, so every port reads zero while rst is high.
            if (rst || (ZERO_REG && (ra == '0))) begin
                rdat = '0;
                rbsy = 1'b0;
            end
            rd_data[p*XLEN +: XLEN] = rdat;
            rd_busy[p]              = rbsy;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Testbench for reg_file_mp.
// - Instance A uses the default configuration, with bypass enabled.
// - Instance B is 64 bits wide, has 16 registers, 3 read ports and no bypass.
// - Each instance is checked against an array-based model of the register file.
module tb_reg_file_mp;

    logic clk;
    int   checks = 0;
    int   errors = 0;

    // Instance A signals.
    logic        rst_a;
    logic [9:0]  rd_addr_a;
    logic [63:0] rd_data_a;
    logic [1:0]  rd_busy_a;
    logic        we0_a, we1_a, res_en_a;
    logic [4:0]  waddr0_a, waddr1_a, res_addr_a;
    logic [31:0] wd0_a, wd1_a;
    logic [31:0] busy_vec_a;

    // Instance B signals.
    logic         rst_b;
    logic [11:0]  rd_addr_b;
    logic [191:0] rd_data_b;
    logic [2:0]   rd_busy_b;
    logic         we0_b, we1_b, res_en_b;
    logic [3:0]   waddr0_b, waddr1_b, res_addr_b;
    logic [63:0]  wd0_b, wd1_b;
    logic [15:0]  busy_vec_b;

    // Reference models.
    logic [31:0] ma  [32];
    logic        mba [32];
    logic [63:0] mb  [16];
    logic        mbb [16];

    reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_a (
        .clk(clk), .rst(rst_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .we0(we0_a), .we1(we1_a), .waddr0(waddr0_a), .waddr1(waddr1_a), .wd0(wd0_a), .wd1(wd1_a),
        .res_en(res_en_a), .res_addr(res_addr_a), .busy_vec(busy_vec_a)
    );

    reg_file_mp #(.XLEN(64), .NREGS(16), .NRD(3), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_b (
        .clk(clk), .rst(rst_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .we0(we0_b), .we1(we1_b), .waddr0(waddr0_b), .waddr1(waddr1_b), .wd0(wd0_b), .wd1(wd1_b),
        .res_en(res_en_b), .res_addr(res_addr_b), .busy_vec(busy_vec_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected read results for the current inputs and model state.
    function automatic logic [31:0] xd_a(input logic [4:0] a);
        if (rst_a || a == 5'd0) return 32'h0;
        if (we1_a && waddr1_a == a) return wd1_a;
        if (we0_a && waddr0_a == a) return wd0_a;
        return ma[a];
    endfunction

    function automatic logic xb_a(input logic [4:0] a);
        if (rst_a || a == 5'd0) return 1'b0;
        if ((we1_a && waddr1_a == a) || (we0_a && waddr0_a == a)) return 1'b0;
        return mba[a];
    endfunction

    function automatic logic [31:0] xv_a();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = mba[i];
        return v;
    endfunction

    function automatic logic [63:0] xd_b(input logic [3:0] a);
        if (rst_b || a == 4'd0) return 64'h0;
        return mb[a];
    endfunction

    function automatic logic xb_b(input logic [3:0] a);
        if (rst_b || a == 4'd0) return 1'b0;
        return mbb[a];
    endfunction

    function automatic logic [15:0] xv_b();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = mbb[i];
        return v;
    endfunction

    task automatic clear_a();
        for (int i = 0; i < 32; i++) begin ma[i] = '0; mba[i] = 1'b0; end
    endtask

    task automatic clear_b();
        for (int i = 0; i < 16; i++) begin mb[i] = '0; mbb[i] = 1'b0; end
    endtask

    task automatic idle_a();
        we0_a = 0; we1_a = 0; waddr0_a = '0; waddr1_a = '0; wd0_a = '0; wd1_a = '0;
        res_en_a = 0; res_addr_a = '0;
    endtask

    task automatic idle_b();
        we0_b = 0; we1_b = 0; waddr0_b = '0; waddr1_b = '0; wd0_b = '0; wd1_b = '0;
        res_en_b = 0; res_addr_b = '0;
    endtask

    // Wait for a rising edge, then apply the write and reserve rules to both models.
    task automatic tick();
        @(posedge clk);
        if (!rst_a) begin
            if (we0_a && waddr0_a != 0) begin ma[waddr0_a] = wd0_a; mba[waddr0_a] = 1'b0; end
            if (we1_a && waddr1_a != 0) begin ma[waddr1_a] = wd1_a; mba[waddr1_a] = 1'b0; end
            if (res_en_a && res_addr_a != 0) mba[res_addr_a] = 1'b1;
        end
        if (!rst_b) begin
            if (we0_b && waddr0_b != 0) begin mb[waddr0_b] = wd0_b; mbb[waddr0_b] = 1'b0; end
            if (we1_b && waddr1_b != 0) begin mb[waddr1_b] = wd1_b; mbb[waddr1_b] = 1'b0; end
            if (res_en_b && res_addr_b != 0) mbb[res_addr_b] = 1'b1;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (rd_data_a !== 64'h0 || busy_vec_a !== 32'h0 || rd_data_b !== 192'h0) begin
            errors++;
            $display("FAIL reset_initial: got a=%h va=%h b=%h, exp all zero", rd_data_a, busy_vec_a, rd_data_b);
        end
        @(negedge clk); rst_a = 0; rst_b = 0;
        idle_a(); we0_a = 1; waddr0_a = 5'd5; wd0_a = 32'hDEADBEEF; res_en_a = 1; res_addr_a = 5'd6;
        tick();
        @(negedge clk); idle_a(); rd_addr_a = {5'd6, 5'd5};
        #1;
        checks++;
        if (rd_data_a[31:0] !== 32'hDEADBEEF || rd_busy_a[1] !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre: got x5=%h busy6=%b, exp deadbeef 1", rd_data_a[31:0], rd_busy_a[1]);
        end
        #2 rst_a = 1; clear_a();
        #1;
        checks++;
        if (rd_data_a[31:0] !== 32'h0 || busy_vec_a !== 32'h0) begin
            errors++;
            $display("FAIL reset_async: got x5=%h vec=%h, exp 0 0", rd_data_a[31:0], busy_vec_a);
        end
        tick(); #1;
        checks++;
        if (rd_data_a[31:0] !== 32'h0 || busy_vec_a !== 32'h0) begin
            errors++;
            $display("FAIL reset_edge: got x5=%h vec=%h, exp 0 0", rd_data_a[31:0], busy_vec_a);
        end
        @(negedge clk); rst_a = 0; #1;
        checks++;
        if (rd_data_a[31:0] !== 32'h0 || rd_busy_a !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: got x5=%h busy=%b, exp 0 0", rd_data_a[31:0], rd_busy_a);
        end
    endtask

    task automatic test_basic();
        @(negedge clk);
        idle_a(); idle_b();
        we0_a = 1; waddr0_a = 5'd3; wd0_a = 32'h12345678; rd_addr_a = {5'd0, 5'd3};
        we0_b = 1; waddr0_b = 4'd3; wd0_b = 64'h12345678; rd_addr_b = {4'd0, 4'd0, 4'd3};
        #1;
        checks++;
        if (rd_data_a[31:0] !== 32'h12345678) begin
            errors++;
            $display("FAIL basic_bypass: got %h exp 12345678", rd_data_a[31:0]);
        end
        checks++;
        if (rd_data_b[63:0] !== 64'h0) begin
            errors++;
            $display("FAIL basic_nobypass_pre: got %h exp 0", rd_data_b[63:0]);
        end
        tick();
        @(negedge clk); idle_a(); idle_b(); #1;
        checks++;
        if (rd_data_a[31:0] !== 32'h12345678) begin
            errors++;
            $display("FAIL basic_stored_a: got %h exp 12345678", rd_data_a[31:0]);
        end
        checks++;
        if (rd_data_b[63:0] !== 64'h12345678) begin
            errors++;
            $display("FAIL basic_stored_b: got %h exp 12345678", rd_data_b[63:0]);
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        idle_a(); we0_a = 1; we1_a = 1; waddr0_a = 5'd7; waddr1_a = 5'd7; wd0_a = 32'h1; wd1_a = 32'h2;
        rd_addr_a = {5'd7, 5'd0};
        #1;
        checks++;
        if (rd_data_a[63:32] !== 32'h2) begin
            errors++;
            $display("FAIL collision_bypass: got %h exp 2", rd_data_a[63:32]);
        end
        tick();
        @(negedge clk); idle_a(); #1;
        checks++;
        if (rd_data_a[63:32] !== 32'h2) begin
            errors++;
            $display("FAIL collision_stored: got %h exp 2", rd_data_a[63:32]);
        end
    endtask

    task automatic test_x0();
        @(negedge clk);
        idle_a(); we1_a = 1; waddr1_a = 5'd0; wd1_a = 32'hFFFFFFFF; res_en_a = 1; res_addr_a = 5'd0;
        rd_addr_a = {5'd0, 5'd0};
        #1;
        checks++;
        if (rd_data_a !== 64'h0 || rd_busy_a !== 2'b00 || busy_vec_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL x0_same: got d=%h b=%b v0=%b exp 0", rd_data_a, rd_busy_a, busy_vec_a[0]);
        end
        tick();
        @(negedge clk); idle_a(); #1;
        checks++;
        if (rd_data_a !== 64'h0 || rd_busy_a !== 2'b00 || busy_vec_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL x0_after: got d=%h b=%b v0=%b exp 0", rd_data_a, rd_busy_a, busy_vec_a[0]);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        idle_a(); res_en_a = 1; res_addr_a = 5'd9; rd_addr_a = {5'd9, 5'd0};
        #1;
        checks++;
        if (rd_busy_a[1] !== 1'b0) begin
            errors++;
            $display("FAIL sb_res_same_cycle: got %b exp 0", rd_busy_a[1]);
        end
        tick();
        @(negedge clk); idle_a(); #1;
        checks++;
        if (rd_busy_a[1] !== 1'b1 || busy_vec_a[9] !== 1'b1) begin
            errors++;
            $display("FAIL sb_reserved: got b=%b v=%b exp 1 1", rd_busy_a[1], busy_vec_a[9]);
        end
        we0_a = 1; waddr0_a = 5'd9; wd0_a = 32'hAA; res_en_a = 1; res_addr_a = 5'd9;
        #1;
        checks++;
        if (rd_data_a[63:32] !== 32'hAA || rd_busy_a[1] !== 1'b0) begin
            errors++;
            $display("FAIL sb_wr_res_bypass: got d=%h b=%b exp aa 0", rd_data_a[63:32], rd_busy_a[1]);
        end
        tick();
        @(negedge clk); idle_a(); #1;
        checks++;
        if (rd_data_a[63:32] !== 32'hAA || rd_busy_a[1] !== 1'b1) begin
            errors++;
            $display("FAIL sb_res_wins: got d=%h b=%b exp aa 1", rd_data_a[63:32], rd_busy_a[1]);
        end
        we1_a = 1; waddr1_a = 5'd9; wd1_a = 32'hBB;
        tick();
        @(negedge clk); idle_a(); #1;
        checks++;
        if (rd_data_a[63:32] !== 32'hBB || rd_busy_a[1] !== 1'b0 || busy_vec_a[9] !== 1'b0) begin
            errors++;
            $display("FAIL sb_cleared: got d=%h b=%b v=%b exp bb 0 0", rd_data_a[63:32], rd_busy_a[1], busy_vec_a[9]);
        end
    endtask

    task automatic test_random_a(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rst_a = 0;
            we0_a = 1'($urandom); we1_a = 1'($urandom); res_en_a = 1'($urandom);
            waddr0_a = 5'($urandom); waddr1_a = ($urandom_range(0, 3) == 0) ? waddr0_a : 5'($urandom);
            res_addr_a = ($urandom_range(0, 3) == 0) ? waddr1_a : 5'($urandom);
            wd0_a = $urandom; wd1_a = $urandom;
            for (int p = 0; p < 2; p++)
                rd_addr_a[p*5 +: 5] = ($urandom_range(0, 2) == 0) ? waddr1_a : 5'($urandom);
            #1;
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (rd_data_a[p*32 +: 32] !== xd_a(rd_addr_a[p*5 +: 5]) ||
                    rd_busy_a[p] !== xb_a(rd_addr_a[p*5 +: 5])) begin
                    errors++;
                    $display("FAIL rnd_a port%0d addr %0d: got d=%h b=%b exp d=%h b=%b", p, rd_addr_a[p*5 +: 5],
                             rd_data_a[p*32 +: 32], rd_busy_a[p], xd_a(rd_addr_a[p*5 +: 5]), xb_a(rd_addr_a[p*5 +: 5]));
                end
            end
            checks++;
            if (busy_vec_a !== xv_a()) begin
                errors++;
                $display("FAIL rnd_a busy_vec: got %h exp %h", busy_vec_a, xv_a());
            end
            if ($urandom_range(0, 39) == 0) begin
                #1 rst_a = 1; clear_a();
                #1;
                checks++;
                if (rd_data_a !== 64'h0 || rd_busy_a !== 2'b00 || busy_vec_a !== 32'h0) begin
                    errors++;
                    $display("FAIL rnd_a reset: got d=%h b=%b v=%h exp 0", rd_data_a, rd_busy_a, busy_vec_a);
                end
            end
            tick();
        end
        @(negedge clk); rst_a = 0; idle_a();
    endtask

    task automatic test_random_b(input int n);
        // Give every non-zero register a distinct value, alternating between the two write ports.
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            idle_b();
            if (i % 2 == 1) begin we0_b = 1; waddr0_b = 4'(i); wd0_b = {32'(i), $urandom}; end
            else begin we1_b = 1; waddr1_b = 4'(i); wd1_b = {32'(i), $urandom}; end
            tick();
        end
        @(negedge clk); idle_b();
        for (int i = 1; i < 16; i++) begin
            rd_addr_b = {4'(i), 4'(i), 4'(i)};
            #1;
            checks++;
            if (rd_data_b[127:64] !== xd_b(4'(i)) || rd_data_b[127:64] === 64'h0) begin
                errors++;
                $display("FAIL fill_b x%0d: got %h exp %h", i, rd_data_b[127:64], xd_b(4'(i)));
            end
        end
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rst_b = 0;
            we0_b = 1'($urandom); we1_b = 1'($urandom); res_en_b = 1'($urandom);
            waddr0_b = 4'($urandom); waddr1_b = ($urandom_range(0, 3) == 0) ? waddr0_b : 4'($urandom);
            res_addr_b = ($urandom_range(0, 3) == 0) ? waddr0_b : 4'($urandom);
            wd0_b = {$urandom, $urandom}; wd1_b = {$urandom, $urandom};
            for (int p = 0; p < 3; p++) rd_addr_b[p*4 +: 4] = 4'($urandom);
            #1;
            for (int p = 0; p < 3; p++) begin
                checks++;
                if (rd_data_b[p*64 +: 64] !== xd_b(rd_addr_b[p*4 +: 4]) ||
                    rd_busy_b[p] !== xb_b(rd_addr_b[p*4 +: 4])) begin
                    errors++;
                    $display("FAIL rnd_b port%0d addr %0d: got d=%h b=%b exp d=%h b=%b", p, rd_addr_b[p*4 +: 4],
                             rd_data_b[p*64 +: 64], rd_busy_b[p], xd_b(rd_addr_b[p*4 +: 4]), xb_b(rd_addr_b[p*4 +: 4]));
                end
            end
            checks++;
            if (busy_vec_b !== xv_b()) begin
                errors++;
                $display("FAIL rnd_b busy_vec: got %h exp %h", busy_vec_b, xv_b());
            end
            if ($urandom_range(0, 49) == 0) begin
                #1 rst_b = 1; clear_b();
                #1;
                checks++;
                if (rd_data_b !== 192'h0 || rd_busy_b !== 3'b000 || busy_vec_b !== 16'h0) begin
                    errors++;
                    $display("FAIL rnd_b reset: got d=%h b=%b v=%h exp 0", rd_data_b, rd_busy_b, busy_vec_b);
                end
            end
            tick();
        end
        @(negedge clk); rst_b = 0; idle_b();
    endtask

    initial begin
        rst_a = 1; rst_b = 1;
        idle_a(); idle_b();
        rd_addr_a = '0; rd_addr_b = '0;
        clear_a(); clear_b();
        repeat (2) @(posedge clk);
        test_reset();
        test_basic();
        test_collision();
        test_x0();
        test_scoreboard();
        test_random_a(300);
        test_random_b(1000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
